// File: rtl/egress_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : egress_packet_arbiter
// Purpose  : Packet-atomic arbiter that merges the processed-packet stream
//            and tagged cycle-count reports onto the packet_constructor path.
// Revision : 1.0 - initial release
// ============================================================================
module egress_packet_arbiter #(
   parameter int         COUNT_WIDTH   = 32,
   parameter logic [7:0] REPORT_TAG    = 8'hC1,
   parameter int         DATA_PRIORITY = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [7:0]             data_in_data,
   input  logic                   data_in_valid,
   output logic                   data_in_ready,
   input  logic                   data_in_last,
   input  logic [COUNT_WIDTH-1:0] count_in,
   input  logic                   count_valid,
   output logic                   count_ready,
   output logic [7:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy
);

   localparam int   c_NUM_BYTES   = COUNT_WIDTH / 8;
   localparam int   c_IDX_W       = $clog2(c_NUM_BYTES + 1);
   localparam logic c_GRANT_DATA  = 1'b0;
   localparam logic c_GRANT_COUNT = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_COUNT = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_last_grant;
   logic                   w_next_last_grant;
   logic [c_IDX_W-1:0]     r_byte_idx;
   logic [c_IDX_W-1:0]     w_next_byte_idx;
   logic                   r_count_pending;
   logic [COUNT_WIDTH-1:0] r_count_reg;
   logic                   w_count_done;
   logic                   w_prefer_data;
   logic                   w_last_idx;
   logic [7:0]             w_count_byte;

   // Gated by reset so no measurement is acknowledged while held in reset.
   assign count_ready   = reset & ~r_count_pending;
   assign busy          = (r_state != S_IDLE) | r_count_pending;
   assign w_prefer_data = (DATA_PRIORITY != 0) || (r_last_grant == c_GRANT_COUNT);
   assign w_last_idx    = (r_byte_idx == c_IDX_W'(c_NUM_BYTES));

   // Index 0 is the tag; index k selects count byte k, most significant first.
   always_comb begin
      w_count_byte = REPORT_TAG;
      for (int k = 1; k <= c_NUM_BYTES; k++) begin
         if (r_byte_idx == c_IDX_W'(k)) begin
            w_count_byte = r_count_reg[COUNT_WIDTH-8*k+7 -: 8];
         end
      end
   end

   always_comb begin
      w_next_state      = r_state;
      w_next_last_grant = r_last_grant;
      w_next_byte_idx   = r_byte_idx;
      w_count_done      = 1'b0;
      out_data          = 8'h00;
      out_valid         = 1'b0;
      out_last          = 1'b0;
      data_in_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (data_in_valid && (!r_count_pending || w_prefer_data)) begin
               w_next_state      = S_DATA;
               w_next_last_grant = c_GRANT_DATA;
            end else if (r_count_pending) begin
               w_next_state      = S_COUNT;
               w_next_last_grant = c_GRANT_COUNT;
               w_next_byte_idx   = '0;
            end
         end
         S_DATA: begin
            out_data      = data_in_data;
            out_valid     = data_in_valid;
            out_last      = data_in_last;
            data_in_ready = out_ready;
            if (data_in_valid && out_ready && data_in_last) begin
               w_next_state = S_IDLE;
            end
         end
         S_COUNT: begin
            out_data  = w_count_byte;
            out_valid = 1'b1;
            out_last  = w_last_idx;
            if (out_ready) begin
               w_next_byte_idx = r_byte_idx + 1'b1;
               if (w_last_idx) begin
                  w_count_done = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= c_GRANT_COUNT;
         r_byte_idx   <= '0;
      end else begin
         r_state      <= w_next_state;
         r_last_grant <= w_next_last_grant;
         r_byte_idx   <= w_next_byte_idx;
      end
   end

   // Completion and capture are exclusive: capture needs pending low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count_pending <= 1'b0;
         r_count_reg     <= '0;
      end else if (w_count_done) begin
         r_count_pending <= 1'b0;
      end else if (count_valid && count_ready) begin
         r_count_pending <= 1'b1;
         r_count_reg     <= count_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_egress_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_egress_packet_arbiter
// Purpose  : Directed self-checking bench for egress_packet_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egress_packet_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  data_in_data = 8'h00;
   logic        data_in_valid = 1'b0;
   logic        data_in_last = 1'b0;
   logic [31:0] count_in = 32'h0;
   logic        count_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        data_in_ready, count_ready, out_valid, out_last, busy;
   logic [7:0]  out_data;
   logic        p_data_in_ready, p_count_ready, p_out_valid, p_out_last, p_busy;
   logic [7:0]  p_out_data;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int drive_cyc;
   logic [7:0] tx_q[$];
   logic [8:0] mon_q[$];
   logic [8:0] exp_q[$];
   int         mon_cyc[$];

   egress_packet_arbiter u_dut (
      .clock(clock), .reset(reset),
      .data_in_data(data_in_data), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .data_in_last(data_in_last),
      .count_in(count_in), .count_valid(count_valid), .count_ready(count_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   egress_packet_arbiter #(.DATA_PRIORITY(1)) u_dut_prio (
      .clock(clock), .reset(reset),
      .data_in_data(data_in_data), .data_in_valid(data_in_valid),
      .data_in_ready(p_data_in_ready), .data_in_last(data_in_last),
      .count_in(count_in), .count_valid(count_valid), .count_ready(p_count_ready),
      .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(out_ready),
      .out_last(p_out_last), .busy(p_busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Output bytes as {last, data}, recorded mid-cycle ahead of the accepting edge.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         mon_q.push_back({out_last, out_data});
         mon_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic send_data();
      logic acc;
      int   t;
      drive_cyc = cyc;
      for (int i = 0; i < tx_q.size(); i++) begin
         data_in_valid = 1'b1;
         data_in_data  = tx_q[i];
         data_in_last  = (i == tx_q.size() - 1);
         t = 0;
         do begin
            @(negedge clock);
            acc = data_in_ready;
            step();
            t++;
         end while (!acc && t < 100);
         if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_data_timeout byte %0d: ready never seen, required within 100 cycles", i);
         end
      end
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
   endtask

   task automatic wait_mon(input int n);
      int t = 0;
      while (mon_q.size() < n && t < 200) begin
         step();
         t++;
      end
      if (mon_q.size() < n) begin
         n_tests++; n_fail++;
         $display("FAIL wait_mon_timeout: got %0d bytes, required %0d", mon_q.size(), n);
      end
      repeat (4) step();
   endtask

   task automatic test_reset();
      count_valid = 1'b1;
      count_in    = 32'hFFFF_FFFF;
      repeat (3) @(posedge clock);
      #2;
      n_tests++;
      if ({out_valid, out_last, out_data, data_in_ready, count_ready, busy} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b l=%b d=%h dr=%b cr=%b busy=%b, required all 0",
                  out_valid, out_last, out_data, data_in_ready, count_ready, busy);
      end
      count_valid = 1'b0;
      count_in    = 32'h0;
      reset       = 1'b1;
      #1;
      n_tests++;
      if (count_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got cr=%b busy=%b, required cr=1 busy=0", count_ready, busy);
      end
      step();
   endtask

   task automatic test_data_only();
      int cr_low = 0;
      mon_q.delete(); mon_cyc.delete();
      tx_q = '{8'h01, 8'h02, 8'h03};
      fork
         send_data();
         for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (count_ready !== 1'b1) cr_low++;
         end
      join
      wait_mon(3);
      exp_q = '{9'h001, 9'h002, 9'h103};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL data_only_bytes: got %p, required %p", mon_q, exp_q);
      end
      n_tests++;
      if (mon_cyc.size() == 0 || mon_cyc[0] != drive_cyc + 1) begin
         n_fail++;
         $display("FAIL data_only_latency: first byte cycle %0d, required %0d",
                  (mon_cyc.size() != 0) ? mon_cyc[0] : -1, drive_cyc + 1);
      end
      n_tests++;
      if (cr_low != 0) begin
         n_fail++;
         $display("FAIL data_only_count_ready: low in %0d cycles, required 0", cr_low);
      end
   endtask

   task automatic test_count_only();
      int         c0;
      logic [6:0] cr;
      mon_q.delete(); mon_cyc.delete();
      count_in = 32'h1234_5678; count_valid = 1'b1; c0 = cyc;
      step();
      count_valid = 1'b0; count_in = 32'h0;
      for (int i = 0; i < 7; i++) begin
         #1;
         cr[i] = count_ready;
         step();
      end
      n_tests++;
      if (cr !== 7'b100_0000) begin
         n_fail++;
         $display("FAIL count_only_ready: got %b (cycles +7..+1), required 1000000", cr);
      end
      wait_mon(5);
      exp_q = '{9'h0C1, 9'h012, 9'h034, 9'h056, 9'h178};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL count_only_bytes: got %p, required %p", mon_q, exp_q);
      end
      n_tests++;
      if (mon_cyc.size() == 0 || mon_cyc[0] != c0 + 2) begin
         n_fail++;
         $display("FAIL count_only_latency: first byte cycle %0d, required %0d",
                  (mon_cyc.size() != 0) ? mon_cyc[0] : -1, c0 + 2);
      end
   endtask

   task automatic test_tie_round_robin();
      int rep_dr_high = 0;
      // Last grant is COUNT here, so data must win this tie.
      mon_q.delete(); mon_cyc.delete();
      count_in = 32'hDEAD_BEEF; count_valid = 1'b1;
      step();
      count_valid = 1'b0;
      tx_q = '{8'hAA, 8'hBB};
      send_data();
      wait_mon(7);
      exp_q = '{9'h0AA, 9'h1BB, 9'h0C1, 9'h0DE, 9'h0AD, 9'h0BE, 9'h1EF};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL tie1_order: got %p, required %p", mon_q, exp_q);
      end
      n_tests++;
      if (mon_cyc.size() < 3 || mon_cyc[2] != mon_cyc[1] + 2) begin
         n_fail++;
         $display("FAIL tie1_gap: report start cycle %0d, required last data cycle + 2",
                  (mon_cyc.size() > 2) ? mon_cyc[2] : -1);
      end
      // A one-byte data packet moves last grant to DATA.
      mon_q.delete(); mon_cyc.delete();
      tx_q = '{8'h11};
      send_data();
      wait_mon(1);
      n_tests++;
      if (mon_q.size() != 1 || mon_q[0] !== 9'h111 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_byte_packet: got %p busy=%b, required '{0x111} busy=0", mon_q, busy);
      end
      // Same tie again: the report now goes first; the priority variant still picks data.
      mon_q.delete(); mon_cyc.delete();
      count_in = 32'hCAFE_F00D; count_valid = 1'b1;
      step();
      count_valid = 1'b0;
      tx_q = '{8'hAA, 8'hBB};
      fork
         send_data();
         begin
            @(negedge clock);
            @(negedge clock);
            n_tests++;
            if (p_out_valid !== 1'b1 || p_out_data !== 8'hAA) begin
               n_fail++;
               $display("FAIL prio_tie: got v=%b d=%h, required v=1 d=aa", p_out_valid, p_out_data);
            end
            for (int i = 0; i < 5; i++) begin
               if (data_in_ready !== 1'b0) rep_dr_high++;
               @(negedge clock);
            end
         end
      join
      wait_mon(7);
      exp_q = '{9'h0C1, 9'h0CA, 9'h0FE, 9'h0F0, 9'h10D, 9'h0AA, 9'h1BB};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL tie2_order: got %p, required %p", mon_q, exp_q);
      end
      n_tests++;
      if (rep_dr_high != 0) begin
         n_fail++;
         $display("FAIL count_stalls_data: data_in_ready high %0d cycles during report, required 0", rep_dr_high);
      end
   endtask

   task automatic test_count_during_data();
      mon_q.delete(); mon_cyc.delete();
      tx_q = '{8'h10, 8'h20, 8'h30, 8'h40};
      fork
         send_data();
         begin
            step();
            step();
            count_in = 32'h0BAD_CAFE; count_valid = 1'b1;
            step();
            count_valid = 1'b0;
         end
      join
      wait_mon(9);
      exp_q = '{9'h010, 9'h020, 9'h030, 9'h140, 9'h0C1, 9'h00B, 9'h0AD, 9'h0CA, 9'h1FE};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL count_during_data: got %p, required %p", mon_q, exp_q);
      end
      n_tests++;
      if (mon_cyc.size() < 5 || mon_cyc[4] != mon_cyc[3] + 2) begin
         n_fail++;
         $display("FAIL count_during_data_gap: report start %0d, required data last + 2",
                  (mon_cyc.size() > 4) ? mon_cyc[4] : -1);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat = 4'b1001;
      int   unstable = 0;
      int   mirror_err = 0;
      logic prev_stall = 1'b0;
      logic [8:0] prev;
      mon_q.delete(); mon_cyc.delete();
      count_in = 32'hFFFF_FFFF; count_valid = 1'b1;
      fork
         for (int i = 0; i < 24; i++) begin
            out_ready = pat[i % 4];
            if (i == 1) count_valid = 1'b0;
            step();
         end
         for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (out_valid && prev_stall && {out_last, out_data} !== prev) unstable++;
            prev_stall = out_valid && !out_ready;
            prev       = {out_last, out_data};
         end
      join
      out_ready = 1'b1;
      wait_mon(5);
      exp_q = '{9'h0C1, 9'h0FF, 9'h0FF, 9'h0FF, 9'h1FF};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL backpressure_report: got %p, required %p", mon_q, exp_q);
      end
      n_tests++;
      if (unstable != 0) begin
         n_fail++;
         $display("FAIL backpressure_stable: %0d changes while stalled, required 0", unstable);
      end
      mon_q.delete(); mon_cyc.delete();
      tx_q = '{8'h5A, 8'hA5};
      fork
         send_data();
         for (int i = 0; i < 12; i++) begin
            out_ready = pat[i % 4];
            #1;
            if (out_valid && data_in_ready !== out_ready) mirror_err++;
            step();
         end
      join
      out_ready = 1'b1;
      wait_mon(2);
      exp_q = '{9'h05A, 9'h1A5};
      n_tests++;
      if (mon_q != exp_q || mirror_err != 0) begin
         n_fail++;
         $display("FAIL backpressure_data: got %p mirror_err=%0d, required %p mirror_err=0",
                  mon_q, mirror_err, exp_q);
      end
   endtask

   task automatic test_reset_mid_report();
      int t = 0;
      mon_q.delete(); mon_cyc.delete();
      count_in = 32'h1234_5678; count_valid = 1'b1;
      step();
      count_valid = 1'b0;
      while (mon_q.size() < 2 && t < 50) begin
         step();
         t++;
      end
      #1;
      reset = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || count_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got v=%b busy=%b cr=%b, required 0 0 0", out_valid, busy, count_ready);
      end
      exp_q = '{9'h0C1, 9'h012};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL reset_truncate: got %p, required %p", mon_q, exp_q);
      end
      step();
      reset = 1'b1;
      #1;
      n_tests++;
      if (busy !== 1'b0 || count_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_recover: got busy=%b cr=%b, required busy=0 cr=1", busy, count_ready);
      end
      step();
      mon_q.delete(); mon_cyc.delete();
      count_in = 32'h0; count_valid = 1'b1;
      step();
      count_valid = 1'b0;
      wait_mon(5);
      exp_q = '{9'h0C1, 9'h000, 9'h000, 9'h000, 9'h100};
      n_tests++;
      if (mon_q != exp_q) begin
         n_fail++;
         $display("FAIL reset_fresh_count: got %p, required %p", mon_q, exp_q);
      end
   endtask

   initial begin
      test_reset();
      test_data_only();
      test_count_only();
      test_tie_round_robin();
      test_count_during_data();
      test_backpressure();
      test_reset_mid_report();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
